// File: rtl/scan_sequencer.sv
// Raster scan scheduler: walks the galvo across an NX x NY grid, handshakes DAC codes,
// waits for settle, fires pix_go per pixel and collects pix_done (or times out).
module scan_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 10,
  parameter int unsigned SW = 16
) (
  input  logic          clk_control,
  input  logic          rst_control_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_nx,
  input  logic [CW-1:0] cfg_ny,
  input  logic [DW-1:0] cfg_x0,
  input  logic [DW-1:0] cfg_y0,
  input  logic [DW-1:0] cfg_dx,
  input  logic [DW-1:0] cfg_dy,
  input  logic [SW-1:0] cfg_settle,
  input  logic [SW-1:0] cfg_timeout,
  input  logic [7:0]    cfg_nframes,
  output logic          galvo_req,
  input  logic          galvo_ack,
  output logic [DW-1:0] galvo_x,
  output logic [DW-1:0] galvo_y,
  output logic          pix_go,
  input  logic          pix_done,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] xi,
  output logic [CW-1:0] yi,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREQ,
    S_SETTLE,
    S_GO,
    S_PWAIT,
    S_ADV
  } state_t;

  state_t state_q, state_d;

  // Shadow configuration captured at start
  logic [CW-1:0] nxm1_q, nxm1_d;
  logic [CW-1:0] nym1_q, nym1_d;
  logic [DW-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [DW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [SW-1:0] timeout_q, timeout_d;
  logic [7:0]    nframes_q, nframes_d;

  logic [SW-1:0] cnt_q, cnt_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          abort_pend_q, abort_pend_d;

  logic          galvo_req_q, galvo_req_d;
  logic [DW-1:0] galvo_x_q, galvo_x_d;
  logic [DW-1:0] galvo_y_q, galvo_y_d;
  logic          pix_go_q, pix_go_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] xi_q, xi_d;
  logic [CW-1:0] yi_q, yi_d;
  logic          err_q, err_d;

  logic [7:0]    fcnt_next;

  assign fcnt_next = fcnt_q + 8'd1;

  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      state_q      <= S_IDLE;
      nxm1_q       <= '0;
      nym1_q       <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      settle_q     <= '0;
      timeout_q    <= '0;
      nframes_q    <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      abort_pend_q <= 1'b0;
      galvo_req_q  <= 1'b0;
      galvo_x_q    <= '0;
      galvo_y_q    <= '0;
      pix_go_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      xi_q         <= '0;
      yi_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nxm1_q       <= nxm1_d;
      nym1_q       <= nym1_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      settle_q     <= settle_d;
      timeout_q    <= timeout_d;
      nframes_q    <= nframes_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      abort_pend_q <= abort_pend_d;
      galvo_req_q  <= galvo_req_d;
      galvo_x_q    <= galvo_x_d;
      galvo_y_q    <= galvo_y_d;
      pix_go_q     <= pix_go_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      xi_q         <= xi_d;
      yi_q         <= yi_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nxm1_d       = nxm1_q;
    nym1_d       = nym1_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    settle_d     = settle_q;
    timeout_d    = timeout_q;
    nframes_d    = nframes_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    abort_pend_d = abort_pend_q;
    galvo_x_d    = galvo_x_q;
    galvo_y_d    = galvo_y_q;
    xi_d         = xi_q;
    yi_d         = yi_q;
    err_d        = err_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          nxm1_d       = (cfg_nx == '0) ? '0 : cfg_nx - CW'(1);
          nym1_d       = (cfg_ny == '0) ? '0 : cfg_ny - CW'(1);
          x0_d         = cfg_x0;
          y0_d         = cfg_y0;
          dx_d         = cfg_dx;
          dy_d         = cfg_dy;
          settle_d     = cfg_settle;
          timeout_d    = cfg_timeout;
          nframes_d    = cfg_nframes;
          fcnt_d       = '0;
          abort_pend_d = 1'b0;
          galvo_x_d    = cfg_x0;
          galvo_y_d    = cfg_y0;
          xi_d         = '0;
          yi_d         = '0;
          err_d        = 1'b0;
          state_d      = S_GREQ;
        end
      end

      // Abort cannot break the handshake; remember it until the writer acks
      S_GREQ: begin
        if (abort) abort_pend_d = 1'b1;
        if (galvo_ack) begin
          abort_pend_d = 1'b0;
          if (abort || abort_pend_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = (settle_q == '0) ? SW'(1) : settle_q;
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SW'(1)) begin
          state_d = S_GO;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end

      S_GO: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = timeout_q;
          state_d = S_PWAIT;
        end
      end

      // pix_done takes priority over a coincident timeout expiry
      S_PWAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pix_done) begin
          state_d = S_ADV;
        end else if (timeout_q != '0) begin
          if (cnt_q == SW'(1)) begin
            err_d   = 1'b1;
            state_d = S_ADV;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
      end

      S_ADV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xi_q != nxm1_q) begin
          xi_d      = xi_q + CW'(1);
          galvo_x_d = galvo_x_q + dx_q;
          state_d   = S_GREQ;
        end else begin
          xi_d      = '0;
          galvo_x_d = x0_q;
          if (yi_q != nym1_q) begin
            yi_d      = yi_q + CW'(1);
            galvo_y_d = galvo_y_q + dy_q;
            state_d   = S_GREQ;
          end else begin
            frame_done_d = 1'b1;
            yi_d         = '0;
            galvo_y_d    = y0_q;
            fcnt_d       = fcnt_next;
            if ((nframes_q != 8'd0) && (fcnt_next == nframes_q)) state_d = S_IDLE;
            else                                                 state_d = S_GREQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake/strobe outputs follow the registered state one-for-one
    galvo_req_d = (state_d == S_GREQ);
    pix_go_d    = (state_d == S_GO);
    busy_d      = (state_d != S_IDLE);
  end

  assign galvo_req   = galvo_req_q;
  assign galvo_x     = galvo_x_q;
  assign galvo_y     = galvo_y_q;
  assign pix_go      = pix_go_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign xi          = xi_q;
  assign yi          = yi_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: plays galvo writer and pixel master with random delays and
// checks codes, indices, latencies and status against an arithmetic model of the raster.
module tb_scan_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = 16;

  logic clk_control = 1'b0;
  always #5 clk_control = ~clk_control;

  logic          rst_control_n, start, abort, galvo_ack, pix_done;
  logic [CW-1:0] cfg_nx, cfg_ny;
  logic [DW-1:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
  logic [SW-1:0] cfg_settle, cfg_timeout;
  logic [7:0]    cfg_nframes;
  logic          galvo_req, pix_go, busy, frame_done, err_timeout;
  logic [DW-1:0] galvo_x, galvo_y;
  logic [CW-1:0] xi, yi;

  int total = 0;
  int bad   = 0;

  // Model configuration
  int          m_nx, m_ny, m_settle, m_timeout, m_nframes;
  logic [15:0] m_x0, m_y0, m_dx, m_dy;

  scan_sequencer #(.DW(DW), .CW(CW), .SW(SW)) dut (
    .clk_control(clk_control), .rst_control_n(rst_control_n),
    .start(start), .abort(abort),
    .cfg_nx(cfg_nx), .cfg_ny(cfg_ny), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .cfg_settle(cfg_settle),
    .cfg_timeout(cfg_timeout), .cfg_nframes(cfg_nframes),
    .galvo_req(galvo_req), .galvo_ack(galvo_ack),
    .galvo_x(galvo_x), .galvo_y(galvo_y),
    .pix_go(pix_go), .pix_done(pix_done), .busy(busy),
    .frame_done(frame_done), .xi(xi), .yi(yi), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_control);
    #1;
  endtask

  function automatic logic [15:0] exp_x(input int i);
    return 16'(int'(m_x0) + i * int'(m_dx));
  endfunction

  function automatic logic [15:0] exp_y(input int i);
    return 16'(int'(m_y0) + i * int'(m_dy));
  endfunction

  task automatic set_cfg(input int nx, input int ny, input logic [15:0] x0, input logic [15:0] dx,
                         input logic [15:0] y0, input logic [15:0] dy, input int settle,
                         input int tmo, input int nfr);
    m_nx = nx; m_ny = ny; m_x0 = x0; m_dx = dx; m_y0 = y0; m_dy = dy;
    m_settle = settle; m_timeout = tmo; m_nframes = nfr;
    cfg_nx = CW'(nx); cfg_ny = CW'(ny); cfg_x0 = x0; cfg_dx = dx; cfg_y0 = y0; cfg_dy = dy;
    cfg_settle = SW'(settle); cfg_timeout = SW'(tmo); cfg_nframes = 8'(nfr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, galvo_req, 0);   chk({tag, "_x"}, galvo_x, 0);
    chk({tag, "_y"}, galvo_y, 0);       chk({tag, "_go"}, pix_go, 0);
    chk({tag, "_busy"}, busy, 0);       chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_xi"}, xi, 0);           chk({tag, "_yi"}, yi, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  // Full scan with the bench as galvo writer and pixel master. to_pixel: pixel of frame 0
  // whose pix_done never arrives; frames_cont: frames to run when nframes=0, then abort.
  task automatic run_scan(input int to_pixel, input int frames_cont);
    int  nxe, nye, s_eff, frames_run, d, dd, kend;
    bit  tmo, err_exp;
    nxe        = (m_nx == 0) ? 1 : m_nx;
    nye        = (m_ny == 0) ? 1 : m_ny;
    s_eff      = (m_settle == 0) ? 1 : m_settle;
    frames_run = (m_nframes == 0) ? frames_cont : m_nframes;
    err_exp    = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    // Mid-scan configuration changes must not matter
    cfg_nx = CW'($urandom_range(1, 7)); cfg_ny = CW'($urandom_range(1, 7));
    cfg_x0 = DW'($urandom); cfg_dx = DW'($urandom); cfg_settle = SW'($urandom_range(0, 9));
    chk("err_cleared", err_timeout, 0);
    for (int f = 0; f < frames_run; f++) begin
      for (int y = 0; y < nye; y++) begin
        for (int x = 0; x < nxe; x++) begin
          chk("req", galvo_req, 1);
          chk("busy", busy, 1);
          chk("gx", galvo_x, exp_x(x));
          chk("gy", galvo_y, exp_y(y));
          chk("xi", xi, x);
          chk("yi", yi, y);
          chk("fd_edge", frame_done, (x == 0 && y == 0 && f > 0) ? 1 : 0);
          d = $urandom_range(0, 4);
          for (int i = 0; i < d; i++) begin
            start = ($urandom_range(0, 2) == 0);
            tick;
            chk("req_hold", galvo_req, 1);
            chk("gx_hold", galvo_x, exp_x(x));
            chk("gy_hold", galvo_y, exp_y(y));
          end
          start     = 1'b0;
          galvo_ack = 1'b1;
          tick;
          galvo_ack = 1'b0;
          chk("fd_pulse", frame_done, 0);
          for (int j = 1; j <= s_eff; j++) begin
            chk("go_early", pix_go, 0);
            tick;
          end
          chk("go", pix_go, 1);
          dd   = (f == 0 && (y * nxe + x) == to_pixel) ? 1000 : int'($urandom_range(1, 5));
          tmo  = (m_timeout != 0) && (dd > m_timeout);
          kend = tmo ? m_timeout : dd;
          tick;
          for (int k = 1; k < kend; k++) begin
            chk("pwait_go", pix_go, 0);
            tick;
          end
          if (!tmo) pix_done = 1'b1;
          tick;
          pix_done = 1'b0;
          err_exp  = err_exp | tmo;
          chk("adv_req", galvo_req, 0);
          chk("err", err_timeout, err_exp);
          tick;
        end
      end
    end
    chk("fd_end", frame_done, 1);
    if (m_nframes != 0) begin
      chk("end_busy", busy, 0);
      chk("end_req", galvo_req, 0);
      chk("end_xi", xi, 0);
      chk("end_yi", yi, 0);
      chk("end_gx", galvo_x, m_x0);
      chk("end_gy", galvo_y, m_y0);
      tick;
      chk("fd_once", frame_done, 0);
      chk("err_sticky", err_timeout, err_exp);
    end else begin
      // Continuous: abort in GREQ waits for the (late) ack
      chk("cont_req", galvo_req, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      for (int i = 0; i < 7; i++) begin
        chk("abort_req_hold", galvo_req, 1);
        tick;
      end
      galvo_ack = 1'b1;
      tick;
      galvo_ack = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_req", galvo_req, 0);
      for (int i = 0; i < 4; i++) begin
        chk("abort_nogo", pix_go, 0);
        chk("abort_nofd", frame_done, 0);
        tick;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_control_n = 1'b0;
    start = 1'b0; abort = 1'b0; galvo_ack = 1'b0; pix_done = 1'b0;
    set_cfg(1, 1, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 1);
    repeat (3) @(posedge clk_control);
    #1;
    check_all_zero("rst");
    @(negedge clk_control);
    rst_control_n = 1'b1;
    tick;

    // Basic raster: X 100,110,120 at Y 50 then 45
    set_cfg(3, 2, 16'd100, 16'd10, 16'd50, 16'hFFFB, 4, 0, 1);
    run_scan(-1, 0);

    // settle 0 and 1 both give a single settle cycle
    set_cfg(2, 1, 16'h1234, 16'h0001, 16'h0, 16'h0, 0, 0, 1);
    run_scan(-1, 0);
    set_cfg(2, 1, 16'h1234, 16'h0001, 16'h0, 16'h0, 1, 0, 1);
    run_scan(-1, 0);

    // Timeout on pixel 2, scan completes, err sticky; next start clears it
    set_cfg(2, 2, 16'd0, 16'd3, 16'd7, 16'd1, 2, 20, 1);
    run_scan(1, 0);

    // DAC code wrap, then continuous frames ended by abort
    set_cfg(2, 1, 16'hFFF0, 16'h0020, 16'h0, 16'h0, 1, 0, 1);
    run_scan(-1, 0);
    set_cfg(2, 2, 16'h0100, 16'h0008, 16'h0200, 16'hFFF0, 2, 0, 0);
    run_scan(-1, 3);

    // Abort during PWAIT; late pix_done ignored
    set_cfg(2, 1, 16'd5, 16'd1, 16'd5, 16'd1, 1, 0, 1);
    start = 1'b1; tick; start = 1'b0;
    galvo_ack = 1'b1; tick; galvo_ack = 1'b0;
    tick;
    chk("pw_go", pix_go, 1);
    tick;
    abort = 1'b1; tick; abort = 1'b0;
    chk("pw_abort_busy", busy, 0);
    pix_done = 1'b1; tick; pix_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pw_nogo", pix_go, 0);
      chk("pw_noreq", galvo_req, 0);
      chk("pw_nofd", frame_done, 0);
      tick;
    end

    // start with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_req", galvo_req, 0);

    // Randomized configurations, with timeouts short enough to race pix_done
    for (int r = 0; r < 6; r++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), $urandom_range(0, 6), $urandom_range(0, 5),
              $urandom_range(1, 2));
      run_scan(-1, 0);
    end

    // Async reset in SETTLE after an earlier timeout set err_timeout
    set_cfg(2, 1, 16'h0040, 16'h0004, 16'h0030, 16'h0, 4, 3, 1);
    start = 1'b1; tick; start = 1'b0;
    galvo_ack = 1'b1; tick; galvo_ack = 1'b0;
    repeat (4) tick;
    chk("rs_go", pix_go, 1);
    repeat (4) tick;
    chk("rs_err", err_timeout, 1);
    tick;
    chk("rs_req", galvo_req, 1);
    galvo_ack = 1'b1; tick; galvo_ack = 1'b0;
    #2;
    rst_control_n = 1'b0;
    #1;
    check_all_zero("rs");
    @(negedge clk_control);
    rst_control_n = 1'b1;
    tick;
    check_all_zero("rs_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
